// File: rtl/uart_rx_fifo_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_port_if
//  Description : UART byte strobe plus 6502-style register bus bundle for the
//                receive FIFO port. The master side is the UART front-end and
//                CPU; the slave side is the FIFO peripheral.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_port_if;
  logic [7:0] uart_byte;
  logic       uart_byte_ready;
  logic       bus_en;
  logic       bus_rw;
  logic       bus_addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       irq_n;

  modport master (
    output uart_byte, uart_byte_ready, bus_en, bus_rw, bus_addr, bus_wdata,
    input  bus_rdata, irq_n
  );

  modport slave (
    input  uart_byte, uart_byte_ready, bus_en, bus_rw, bus_addr, bus_wdata,
    output bus_rdata, irq_n
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo_port.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_port
//  Description : Receive FIFO behind the UART front-end, exposed to the CPU as
//                a DATA register (addr 0) and a STATUS/CTRL register (addr 1),
//                with an active-low interrupt while data is pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_port #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_fifo_port_if.slave   bus
);

  localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overrun;
  logic                  r_irq_en;
  logic [7:0]            r_rdata;

  logic       w_avail;
  logic       w_full;
  logic       w_rd;
  logic       w_pop;
  logic       w_push;
  logic       w_overrun_evt;
  logic       w_ctrl_wr;
  logic [7:0] w_status;
  logic       unused_wdata;

  // Decode bus strobes and FIFO events from registered state only.
  always_comb begin
    w_avail       = (r_count != '0);
    w_full        = (r_count == FULL_COUNT);
    w_rd          = bus.bus_en & bus.bus_rw;
    // An empty DATA read never pops, even if a byte arrives in the same cycle.
    w_pop         = w_rd & ~bus.bus_addr & w_avail;
    // A full FIFO can still accept a byte when a pop frees a slot this cycle.
    w_push        = bus.uart_byte_ready & (~w_full | w_pop);
    w_overrun_evt = bus.uart_byte_ready & w_full & ~w_pop;
    w_ctrl_wr     = bus.bus_en & ~bus.bus_rw & bus.bus_addr;
    w_status      = {4'h0, r_irq_en, r_overrun, w_full, w_avail};
  end

  // Only bits 3 and 2 of a CTRL write carry meaning.
  assign unused_wdata = ^{bus.bus_wdata[7:4], bus.bus_wdata[1:0]};

  // Storage array; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.uart_byte;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at their width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Control bits: irq_en load and sticky overrun, where a new overrun beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
      r_irq_en  <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_irq_en <= bus.bus_wdata[3];
      end
      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
      end else if (w_ctrl_wr && bus.bus_wdata[2]) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // Registered read data; holds its value on every non-read cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 8'h00;
    end else if (w_rd) begin
      if (bus.bus_addr) begin
        r_rdata <= w_status;
      end else if (w_pop) begin
        r_rdata <= r_mem[r_rd_ptr];
      end else begin
        r_rdata <= 8'h00;
      end
    end
  end

  assign bus.bus_rdata = r_rdata;
  assign bus.irq_n     = ~(r_irq_en & w_avail);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo_port
//  Description : Self-checking bench for uart_rx_fifo_port: vector table,
//                hand-written corner sequences and randomized traffic against
//                a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo_port;

  logic clk;
  logic rst_n;

  uart_rx_fifo_port_if bif ();

  uart_rx_fifo_port #(.DEPTH_LOG2(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: byte queue plus control flags and last read value.
  logic [7:0] mq[$];
  bit         m_ovr;
  bit         m_ien;
  logic [7:0] m_rd;

  typedef struct {
    logic       rdy;
    logic [7:0] b;
    logic       en;
    logic       rw;
    logic       addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    logic       exp_irq_n;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic logic m_irq_n();
    return !(m_ien && mq.size() != 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovr = 1'b0;
    m_ien = 1'b0;
    m_rd  = 8'h00;
  endtask

  // Model one clock edge from the rules: reads see pre-edge state, a read pops
  // before a byte is appended, a dropped byte sets overrun after any clear.
  task automatic model_edge(input logic rdy, input logic [7:0] b, input logic en,
                            input logic rw, input logic addr, input logic [7:0] wd);
    int pre;
    pre = mq.size();
    if (en && rw) begin
      if (!addr) m_rd = (pre > 0) ? mq.pop_front() : 8'h00;
      else       m_rd = {4'h0, m_ien, m_ovr, pre == 16, pre != 0};
    end
    if (en && !rw && addr) begin
      m_ien = wd[3];
      if (wd[2]) m_ovr = 1'b0;
    end
    if (rdy) begin
      if (mq.size() < 16) mq.push_back(b);
      else                m_ovr = 1'b1;
    end
  endtask

  // Drive one cycle of stimulus (called 1 ns after a rising edge), clock it,
  // then compare outputs 1 ns after the edge against the model.
  task automatic apply(input logic rdy, input logic [7:0] b, input logic en,
                       input logic rw, input logic addr, input logic [7:0] wd);
    bif.uart_byte_ready = rdy;
    bif.uart_byte       = b;
    bif.bus_en          = en;
    bif.bus_rw          = rw;
    bif.bus_addr        = addr;
    bif.bus_wdata       = wd;
    @(posedge clk);
    model_edge(rdy, b, en, rw, addr, wd);
    #1;
    bif.uart_byte_ready = 1'b0;
    bif.bus_en          = 1'b0;
    check("model_rdata", bif.bus_rdata, m_rd);
    check("model_irq_n", {7'h0, bif.irq_n}, {7'h0, m_irq_n()});
  endtask

  task automatic push(input logic [7:0] b);
    apply(1'b1, b, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd_data();
    apply(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic rd_status();
    apply(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00);
  endtask

  task automatic wr_ctrl(input logic [7:0] wd);
    apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, wd);
  endtask

  initial begin
    rst_n               = 1'b0;
    bif.uart_byte       = 8'h00;
    bif.uart_byte_ready = 1'b0;
    bif.bus_en          = 1'b0;
    bif.bus_rw          = 1'b0;
    bif.bus_addr        = 1'b0;
    bif.bus_wdata       = 8'h00;
    model_reset();

    //           rdy   byte   en    rw    addr  wdata  exp_rd irq_n
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1}; // STATUS after reset
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1}; // empty DATA read
    vecs[2]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h41, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h42, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h43, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h08, 8'h00, 1'b1}; // irq_en on
    vecs[10] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}; // irq falls
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h09, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h55, 1'b1}; // irq rises
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h08, 1'b1};
    vecs[14] = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0}; // push+read empty
    vecs[15] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h00, 8'h09, 1'b0}; // STATUS pre-push
    vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h66, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h77, 1'b1};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h77, 1'b1}; // irq_en off
    vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h77, 1'b1}; // DATA write ignored
    vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1};

    #12;
    check("reset_rdata", bif.bus_rdata, 8'h00);
    check("reset_irq_n", {7'h0, bif.irq_n}, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table.
    for (int i = 0; i < 21; i++) begin
      apply(vecs[i].rdy, vecs[i].b, vecs[i].en, vecs[i].rw, vecs[i].addr, vecs[i].wd);
      check($sformatf("vec%0d_rdata", i), bif.bus_rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq_n", i), {7'h0, bif.irq_n}, {7'h0, vecs[i].exp_irq_n});
    end

    // Overrun: 17 pushes into an empty FIFO drop the last byte.
    for (int i = 0; i < 17; i++) push(8'(i));
    rd_status();
    check("ovr_status", bif.bus_rdata, 8'h07);
    for (int i = 0; i < 16; i++) begin
      rd_data();
      check("ovr_drain", bif.bus_rdata, 8'(i));
    end
    rd_data();
    check("ovr_empty_read", bif.bus_rdata, 8'h00);
    wr_ctrl(8'h04);
    rd_status();
    check("ovr_cleared", bif.bus_rdata, 8'h00);

    // Full FIFO with simultaneous push and pop: no overrun, count stays full.
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    apply(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 8'h00);
    check("full_pushpop", bif.bus_rdata, 8'h80);
    rd_status();
    check("full_pushpop_status", bif.bus_rdata, 8'h03);
    for (int i = 1; i < 16; i++) begin
      rd_data();
      check("full_drain", bif.bus_rdata, 8'h80 + 8'(i));
    end
    rd_data();
    check("full_aa", bif.bus_rdata, 8'hAA);

    // Overrun and clear in the same cycle: set wins.
    for (int i = 0; i < 16; i++) push(8'(i));
    apply(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 8'h04);
    rd_status();
    check("set_wins", bif.bus_rdata, 8'h07);
    wr_ctrl(8'h04);
    for (int i = 0; i < 16; i++) rd_data();
    rd_status();
    check("set_wins_drained", bif.bus_rdata, 8'h00);

    // Randomized traffic with frequent pops to exercise pointer wrap.
    for (int i = 0; i < 400; i++) begin
      logic       en;
      logic       rw;
      logic       addr;
      logic [7:0] wd;
      en   = 1'($urandom_range(0, 1));
      rw   = ($urandom_range(0, 9) < 7);
      addr = ($urandom_range(0, 9) < 2);
      wd   = 8'($urandom);
      apply(1'($urandom_range(0, 1)), 8'($urandom), en, rw, addr, wd);
    end

    // Mid-stream asynchronous reset with data pending and interrupts on.
    wr_ctrl(8'h08);
    for (int i = 0; i < 5; i++) apply(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b1, 1'b0, 8'h00);
    push(8'hD0);
    check("pre_reset_irq_n", {7'h0, bif.irq_n}, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_irq_n", {7'h0, bif.irq_n}, 8'h01);
    check("async_rst_rdata", bif.bus_rdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_status();
    check("post_rst_status", bif.bus_rdata, 8'h00);
    push(8'h5A);
    rd_data();
    check("post_rst_data", bif.bus_rdata, 8'h5A);
    rd_data();
    check("post_rst_empty", bif.bus_rdata, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo_port.md
# uart_rx_fifo_port

Receive buffer and CPU register port placed directly downstream of the UART receive front-end. It captures each received byte, signalled by a one-cycle strobe, into a small FIFO. It exposes the FIFO to the 6502 bus as a two-register peripheral: data and status/control. It also drives an active-low interrupt while data is pending and interrupts are enabled.

## Interface
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 entries)
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- uart_byte  in  8  received byte, valid only while uart_byte_ready is high
- uart_byte_ready  in  1  one-cycle strobe from the UART receiver; never held more than one cycle per byte
- bus_en  in  1  one-cycle access strobe, exactly one pulse per CPU access
- bus_rw  in  1  1 = read, 0 = write; sampled with bus_en
- bus_addr  in  1  0 = DATA register, 1 = STATUS/CTRL register
- bus_wdata  in  8  write data; sampled with bus_en when bus_rw = 0
- bus_rdata  out  8  registered read data
- irq_n  out  1  active-low interrupt request

## Operation
- FIFO: DEPTH-entry circular buffer with read pointer, write pointer, and a count of width DEPTH_LOG2+1; pointers wrap modulo DEPTH.
- Push: on uart_byte_ready, when count < DEPTH, or when count = DEPTH and a pop occurs in the same cycle:
  - write uart_byte at the write pointer;
  - increment the write pointer.
- Overrun: uart_byte_ready with count = DEPTH and no simultaneous pop drops the byte. FIFO contents are unchanged and the sticky `overrun` flag is set.
- Pop: read of DATA (bus_en & bus_rw & addr = 0) with count > 0 loads bus_rdata from the head entry and increments the read pointer.
- Read of DATA when empty returns 0x00. Pointers are unchanged.
- Simultaneous push and pop: both take effect and count is unchanged. With count = 0, a same-cycle push and DATA read returns 0x00, does not pop, and leaves count = 1.
- STATUS read (addr = 1) has no side effects. bus_rdata bits:
  - bit0: rx_avail (count != 0)
  - bit1: full (count = DEPTH)
  - bit2: overrun
  - bit3: irq_en
  - bits7:4: 0
- CTRL write (addr = 1):
  - bit3 loads irq_en;
  - bit2 = 1 clears overrun (write-one-to-clear);
  - other bits are ignored.
  - If an overrun event coincides with a clear, set wins.
- DATA write (addr = 0) is ignored.
- Non-read cycles: bus_rdata holds its last value.
- irq_n = ~(irq_en & rx_avail). It is derived only from registered state; there is no combinational path from any input.

## Timing
- Reset values: pointers 0, count 0, overrun 0, irq_en 0, bus_rdata 0x00, irq_n 1. Memory contents are don't-care.
- Reset is asynchronous. Assertion mid-operation empties the FIFO immediately. The first push is accepted on the first rising edge after release on which uart_byte_ready is high.
- Read latency: bus_rdata is valid on the cycle after the bus_en cycle (registered at the bus_en edge) and holds until the next read.
- Push latency: a byte strobed at edge N is visible in status at N+1 (rx_avail = 1, irq_n low if enabled) and is readable from a DATA read issued at N+1.
- Status reflects state after the previous edge. A STATUS read in the same cycle as a push reports the pre-push count.
- Throughput: one push and one pop per cycle.

## Test plan
- Reset, then STATUS read -> bus_rdata = 0x00, irq_n = 1; DATA read -> 0x00.
- Push 0x41, 0x42, 0x43 on separate strobes, then three DATA reads -> 0x41, 0x42, 0x43 in order; final STATUS = 0x00.
- Push 17 bytes 0x00..0x10 with no reads -> STATUS = 0x07 (avail, full, overrun); 16 reads -> 0x00..0x0F; the 0x10 byte is absent. Then CTRL write 0x04 -> STATUS = 0x00.
- Fill to 16 entries, then push 0xAA on the same cycle as a DATA read -> read returns the oldest byte, no overrun, count stays 16; 0xAA emerges after 15 further reads.
- CTRL write 0x08, push one byte -> irq_n falls one cycle after the strobe; DATA read -> irq_n returns high the cycle after the pop; STATUS = 0x08.
- Push 20 bytes with continuous pops interleaved, exercising pointer wrap; assert rst_n low mid-stream -> STATUS = 0x00 and irq_n = 1 immediately; post-reset data starts fresh.
